// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution unit: id_op modes, 2-bit predictor
// counter states and the predictor reset value.
package branch_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_BLT  = 3'b010,
        OP_BGE  = 3'b011,
        OP_BLTU = 3'b100,
        OP_BGEU = 3'b101
    } branch_op_e;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_e;

    localparam ctr_e BHT_RESET = CTR_WEAK_NT;

    // Saturating step of a predictor counter toward the resolved outcome.
    function automatic ctr_e ctr_train(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        if (taken) begin
            if (c != CTR_STRONG_T) r = ctr_e'(c + 2'd1);
        end else begin
            if (c != CTR_STRONG_NT) r = ctr_e'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: signed/unsigned compare modes,
// legacy equality flag and illegal-mode detection.
module branch_cond
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rd1_i,
    input  logic [WIDTH-1:0] rd2_i,
    output logic             taken_o,
    output logic             equal_o,
    output logic             illegal_o
);

    logic lt_s;
    logic lt_u;

    assign equal_o = (rd1_i == rd2_i);
    assign lt_s    = ($signed(rd1_i) < $signed(rd2_i));
    assign lt_u    = (rd1_i < rd2_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (branch_op_e'(op_i))
            OP_BEQ:  taken_o = equal_o;
            OP_BNE:  taken_o = ~equal_o;
            OP_BLT:  taken_o = lt_s;
            OP_BGE:  taken_o = ~lt_s;
            OP_BLTU: taken_o = lt_u;
            OP_BGEU: taken_o = ~lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_compare_unit.sv
// Branch resolution stage with 2-bit saturating-counter predictor table.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_compare_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                if_pred_taken,
    input  logic                id_valid,
    input  logic [2:0]          id_op,
    input  logic [WIDTH-1:0]    id_rd1,
    input  logic [WIDTH-1:0]    id_rd2,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic                id_pred_taken,
    input  logic                stall,
    input  logic                flush,
    output logic                res_valid,
    output logic                res_taken,
    output logic                res_equal,
    output logic                res_mispredict,
    output logic                res_illegal,
    input  logic                stat_clear,
    output logic [CNT_W-1:0]    stat_branches,
    output logic [CNT_W-1:0]    stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic cond_taken;
    logic cond_equal;
    logic cond_illegal;
    logic acc;
    logic mis_now;

    branch_cond #(
        .WIDTH (WIDTH)
    ) u_cond (
        .op_i      (id_op),
        .rd1_i     (id_rd1),
        .rd2_i     (id_rd2),
        .taken_o   (cond_taken),
        .equal_o   (cond_equal),
        .illegal_o (cond_illegal)
    );

    assign acc     = id_valid & ~stall & ~flush;
    assign mis_now = cond_taken ^ id_pred_taken;

    logic res_valid_q, res_valid_d;
    logic res_taken_q, res_taken_d;
    logic res_equal_q, res_equal_d;
    logic res_mis_q,   res_mis_d;
    logic res_ill_q,   res_ill_d;

    // Flush dominates stall; taken/equal hold on idle cycles.
    always_comb begin
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        res_equal_d = res_equal_q;
        res_mis_d   = res_mis_q;
        res_ill_d   = res_ill_q;
        if (flush) begin
            res_valid_d = 1'b0;
            res_mis_d   = 1'b0;
            res_ill_d   = 1'b0;
        end else if (!stall) begin
            if (id_valid) begin
                res_valid_d = 1'b1;
                res_taken_d = cond_taken;
                res_equal_d = cond_equal;
                res_ill_d   = cond_illegal;
                res_mis_d   = mis_now;
            end else begin
                res_valid_d = 1'b0;
                res_mis_d   = 1'b0;
                res_ill_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_equal_q <= 1'b0;
            res_mis_q   <= 1'b0;
            res_ill_q   <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            res_equal_q <= res_equal_d;
            res_mis_q   <= res_mis_d;
            res_ill_q   <= res_ill_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_equal      = res_equal_q;
    assign res_mispredict = res_mis_q;
    assign res_illegal    = res_ill_q;

    ctr_e             bht_q [BHT_DEPTH];
    ctr_e             bht_d;
    logic             bht_we;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] look_idx;

    assign upd_idx  = id_pc[IDX_W:1];
    assign look_idx = if_pc[IDX_W:1];
    assign bht_we   = acc & ~cond_illegal;
    assign bht_d    = ctr_train(bht_q[upd_idx], cond_taken);

    // Lookup reads the registered array, so a same-cycle update is seen next cycle.
    assign if_pred_taken = bht_q[look_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_RESET;
            end
        end else if (bht_we) begin
            bht_q[upd_idx] <= bht_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[0], id_pc[0],
                              if_pc[PC_WIDTH-1:IDX_W+1], id_pc[PC_WIDTH-1:IDX_W+1]};

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_br_q,  stat_br_d;
    logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (stat_clear) begin
            stat_br_d  = '0;
            stat_mis_d = '0;
        end else if (acc) begin
            if (stat_br_q != '1) stat_br_d = stat_br_q + CNT_W'(1);
            if (mis_now && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_branches     = '0;
    assign stat_mispredicts  = '0;
`endif

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit: directed vector table, hand
// sequences for predictor/stall/flush/statistics corners, and randomized traffic.
module tb_branch_compare_unit;

    localparam int SAT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_pc = '0;
    logic        if_pred_taken;
    logic        id_valid = 1'b0;
    logic [2:0]  id_op = '0;
    logic [15:0] id_rd1 = '0;
    logic [15:0] id_rd2 = '0;
    logic [15:0] id_pc = '0;
    logic        id_pred_taken = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        res_valid, res_taken, res_equal, res_mispredict, res_illegal;
    logic        stat_clear = 1'b0;
    logic [3:0]  stat_branches, stat_mispredicts;

    branch_compare_unit #(
        .WIDTH     (16),
        .PC_WIDTH  (16),
        .BHT_DEPTH (16),
        .CNT_W     (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .id_valid         (id_valid),
        .id_op            (id_op),
        .id_rd1           (id_rd1),
        .id_rd2           (id_rd2),
        .id_pc            (id_pc),
        .id_pred_taken    (id_pred_taken),
        .stall            (stall),
        .flush            (flush),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_equal        (res_equal),
        .res_mispredict   (res_mispredict),
        .res_illegal      (res_illegal),
        .stat_clear       (stat_clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int m_valid, m_taken, m_equal, m_mis, m_ill;
    int bht [16];
    int st_br, st_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) >> 1) % 16;
    endfunction

    function automatic void ref_cond(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output int t, output int e, output int il);
        int ua, ub, sa, sb;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        e  = (ua == ub) ? 1 : 0;
        il = 0;
        case (int'(op))
            0: t = e;
            1: t = 1 - e;
            2: t = (sa < sb) ? 1 : 0;
            3: t = (sa >= sb) ? 1 : 0;
            4: t = (ua < ub) ? 1 : 0;
            5: t = (ua >= ub) ? 1 : 0;
            default: begin t = 0; il = 1; end
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_equal = 0; m_mis = 0; m_ill = 0;
        for (int i = 0; i < 16; i++) bht[i] = 1;
        st_br = 0; st_mis = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int t, e, il, k, acc;
        acc = (id_valid && !stall && !flush) ? 1 : 0;
        if (flush) begin
            m_valid = 0; m_mis = 0; m_ill = 0;
        end else if (!stall) begin
            if (id_valid) begin
                ref_cond(id_op, id_rd1, id_rd2, t, e, il);
                m_valid = 1; m_taken = t; m_equal = e; m_ill = il;
                m_mis = (t != int'(id_pred_taken)) ? 1 : 0;
                if (il == 0) begin
                    k = idx_of(id_pc);
                    if (t == 1) bht[k] = (bht[k] < 3) ? bht[k] + 1 : 3;
                    else        bht[k] = (bht[k] > 0) ? bht[k] - 1 : 0;
                end
            end else begin
                m_valid = 0; m_mis = 0; m_ill = 0;
            end
        end
`ifdef BRANCH_STATS_EN
        if (stat_clear) begin
            st_br = 0; st_mis = 0;
        end else if (acc == 1) begin
            if (st_br < SAT) st_br++;
            if (m_mis == 1 && st_mis < SAT) st_mis++;
        end
`endif
    endtask

    task automatic check_all();
        chk("res_valid",      32'(res_valid),      32'(m_valid));
        chk("res_taken",      32'(res_taken),      32'(m_taken));
        chk("res_equal",      32'(res_equal),      32'(m_equal));
        chk("res_mispredict", 32'(res_mispredict), 32'(m_mis));
        chk("res_illegal",    32'(res_illegal),    32'(m_ill));
        chk("if_pred_taken",  32'(if_pred_taken),  (bht[idx_of(if_pc)] >= 2) ? 32'd1 : 32'd0);
        chk("stat_branches",  32'(stat_branches),  32'(st_br));
        chk("stat_mispredicts", 32'(stat_mispredicts), 32'(st_mis));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic pred);
        id_valid = v; id_op = op; id_rd1 = a; id_rd2 = b; id_pc = pc; id_pred_taken = pred;
        stall = 1'b0; flush = 1'b0; stat_clear = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        exp_taken;
        logic        exp_equal;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{3'b000, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b010, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{3'b100, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{3'b111, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Reset then BEQ equal with pred=0: taken, equal, mispredict; entry trained to weak-T.
        if_pc = 16'h0040;
        drive(1'b1, 3'b000, 16'h1234, 16'h1234, 16'h0040, 1'b0);
        tick();
        chk("beq_taken", 32'(res_taken), 32'd1);
        chk("beq_equal", 32'(res_equal), 32'd1);
        chk("beq_mispredict", 32'(res_mispredict), 32'd1);
        chk("beq_pred_after", 32'(if_pred_taken), 32'd1);

        // Vector table on fresh predictor entries.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].rd1, vecs[i].rd2, 16'h0100 + 16'(2 * i), 1'b0);
            tick();
            chk($sformatf("vec%0d_taken", i),   32'(res_taken),   32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_equal", i),   32'(res_equal),   32'(vecs[i].exp_equal));
            chk($sformatf("vec%0d_illegal", i), 32'(res_illegal), 32'(vecs[i].exp_illegal));
            chk($sformatf("vec%0d_mispred", i), 32'(res_mispredict), 32'(vecs[i].exp_taken));
        end
        if_pc = 16'h0110;
        #1;
        chk("illegal_no_train", 32'(if_pred_taken), 32'd0);

        // Predictor training at 0x0010; same-cycle lookup shows pre-update value.
        do_reset();
        if_pc = 16'h0010;
        drive(1'b1, 3'b000, 16'h0007, 16'h0007, 16'h0010, 1'b1);
        #1;
        chk("pred_pre_update", 32'(if_pred_taken), 32'd0);
        tick();
        chk("pred_after_1st", 32'(if_pred_taken), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pred_taken_run", 32'(if_pred_taken), 32'd1);
        end
        drive(1'b1, 3'b001, 16'h0007, 16'h0007, 16'h0010, 1'b1);
        tick();
        chk("pred_after_nt", 32'(if_pred_taken), 32'd1);
        if_pc = 16'h0030;
        #1;
        chk("pred_alias", 32'(if_pred_taken), 32'd1);
        tick();
        chk("pred_alias_2nt", 32'(if_pred_taken), 32'd0);

        // Stall with changing ID inputs freezes results and the predictor.
        do_reset();
        if_pc = 16'h0060;
        drive(1'b1, 3'b001, 16'h0001, 16'h0001, 16'h0020, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b000, 16'(i), 16'(i), 16'h0060, 1'b0);
            stall = 1'b1;
            tick();
            chk("stall_valid_hold", 32'(res_valid), 32'd1);
            chk("stall_taken_hold", 32'(res_taken), 32'd0);
            chk("stall_no_train",   32'(if_pred_taken), 32'd0);
        end
        flush = 1'b1;
        tick();
        chk("flush_stall_valid", 32'(res_valid), 32'd0);
        chk("flush_stall_no_train", 32'(if_pred_taken), 32'd0);
        drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();

`ifdef BRANCH_STATS_EN
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'b000, 16'h00AA, 16'h00AA, 16'h0200, 1'b0);
            tick();
        end
        chk("stat_br_sat",  32'(stat_branches),    32'hF);
        chk("stat_mis_sat", 32'(stat_mispredicts), 32'hF);
        stat_clear = 1'b1;
        tick();
        chk("stat_clear_br",  32'(stat_branches),    32'h0);
        chk("stat_clear_mis", 32'(stat_mispredicts), 32'h0);
        stat_clear = 1'b0;
`endif

        // Randomized traffic against the model, with one mid-stream reset.
        for (int c = 0; c < 600; c++) begin
            logic [15:0] a;
            if (c == 300) do_reset();
            a = 16'($urandom);
            id_valid      = ($urandom % 4) != 0;
            id_op         = 3'($urandom);
            id_rd1        = a;
            id_rd2        = (($urandom % 4) == 0) ? a : 16'($urandom);
            id_pc         = 16'($urandom);
            id_pred_taken = 1'($urandom);
            stall         = ($urandom % 6) == 0;
            flush         = ($urandom % 8) == 0;
            stat_clear    = ($urandom % 25) == 0;
            if_pc         = (($urandom % 2) == 0) ? id_pc : 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
